// File: rtl/array_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// array_mult_arbiter_if
//   Bundle between the requesters, the round-robin arbiter and the shared
//   array_mult instance.
//   slave  : arbiter view (takes requests and mult_result; drives grants,
//            result-valid pulses, the broadcast result and the multiplier operands)
//   master : requester/environment view (the mirror image)
//   req/lock        per-requester request and grant-lock bits
//   dataa/datab     per-requester operands, requester i at [i*LANES*W +: LANES*W]
//   gnt/rvalid      one-hot grant and one-hot result-valid pulse
//   result          mult_result broadcast to all requesters
//   mult_dataa/b    operands steered to array_mult
//   mult_result     product returned by array_mult
// -----------------------------------------------------------------------------
interface array_mult_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int LANES = 6,
   parameter int W     = 27
);
   logic [NREQ-1:0]         req;
   logic [NREQ-1:0]         lock;
   logic [NREQ*LANES*W-1:0] dataa;
   logic [NREQ*LANES*W-1:0] datab;
   logic [NREQ-1:0]         gnt;
   logic [NREQ-1:0]         rvalid;
   logic [LANES*W-1:0]      result;
   logic [LANES*W-1:0]      mult_dataa;
   logic [LANES*W-1:0]      mult_datab;
   logic [LANES*W-1:0]      mult_result;

   modport slave (
      input  req, lock, dataa, datab, mult_result,
      output gnt, rvalid, result, mult_dataa, mult_datab
   );

   modport master (
      output req, lock, dataa, datab, mult_result,
      input  gnt, rvalid, result, mult_dataa, mult_datab
   );
endinterface

// File: rtl/array_mult_arbiter.sv
// -----------------------------------------------------------------------------
// array_mult_arbiter
//   Round-robin arbiter time-sharing one pipelined array_mult between NREQ
//   requesters. Each issue is tagged with the requester index; the tag rides a
//   LAT-deep shift register that advances with en exactly like array_mult, so the
//   product leaving the multiplier is steered back to the requester that issued
//   it, in issue order.
// Ports
//   clk   posedge clock
//   rst   synchronous active-high reset (array_mult shares it)
//   en    global advance enable; en=0 freezes pointer and tag pipeline
//   bus   array_mult_arbiter_if.slave (requests, grants, operands, results)
// -----------------------------------------------------------------------------
module array_mult_arbiter #(
   parameter int NREQ  = 2,
   parameter int LANES = 6,
   parameter int W     = 27,
   parameter int LAT   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   array_mult_arbiter_if.slave  bus
);

   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW    = IDW + 1;
   localparam int SLICE = LANES * W;

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0]  ptr_q, ptr_d;
   tag_t            tag_q [LAT];
   tag_t            tag_d [LAT];
   logic            rst_dly_q, rst_dly_d;

   logic            blocked;
   logic            gnt_any;
   logic [IDW-1:0]  gnt_idx;
   logic [CW-1:0]   cand;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] rvalid;
   logic [SLICE-1:0] mux_a, mux_b;

   // Grants stay off in the reset cycle and the one after it, so nothing issues
   // while array_mult is still coming out of reset.
   assign blocked = rst | rst_dly_q;

   // Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
   // NOTE: every variable written here gets a default first; a missing default
   // on any path would infer a latch.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (en && !blocked) begin
         for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, ptr_q} + CW'(off);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!gnt_any && bus.req[cand[IDW-1:0]]) begin
               gnt_any = 1'b1;
               gnt_idx = cand[IDW-1:0];
            end
         end
      end
   end

   // One-hot grant and operand steering; idle slots push zeros into the multiplier.
   always_comb begin
      gnt   = '0;
      mux_a = '0;
      mux_b = '0;
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
         mux_a        = bus.dataa[gnt_idx*SLICE +: SLICE];
         mux_b        = bus.datab[gnt_idx*SLICE +: SLICE];
      end
   end

   // Pointer and tag pipeline advance only on en cycles; gnt_any already implies en.
   always_comb begin
      ptr_d     = ptr_q;
      tag_d     = tag_q;
      rst_dly_d = rst;
      if (gnt_any) begin
         if (bus.lock[gnt_idx])
            ptr_d = gnt_idx;
         else if (gnt_idx == IDW'(NREQ - 1))
            ptr_d = '0;
         else
            ptr_d = gnt_idx + 1'b1;
      end
      if (en) begin
         tag_d[0].valid = gnt_any;
         tag_d[0].id    = gnt_idx;
         for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];
      end
   end

   // Retire: the oldest tag names the requester that owns the product now on mult_result.
   always_comb begin
      rvalid = '0;
      if (en && !rst && tag_q[LAT-1].valid) rvalid[tag_q[LAT-1].id] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours.
   // NOTE: the tag stages are a handful of flops rather than a memory and must be
   // cleared, otherwise stale tags from before reset would retire afterwards.
   always_ff @(posedge clk) begin
      rst_dly_q <= rst_dly_d;
      if (rst) begin
         ptr_q <= '0;
         for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
      end else begin
         ptr_q <= ptr_d;
         tag_q <= tag_d;
      end
   end

   assign bus.gnt        = gnt;
   assign bus.rvalid     = rvalid;
   assign bus.result     = bus.mult_result;
   assign bus.mult_dataa = mux_a;
   assign bus.mult_datab = mux_b;

endmodule

// File: tb/tb_array_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_array_mult_arbiter
//   Drives requesters through reset, single issue, contention, lock, stall,
//   mid-flight reset and a randomized phase. A tracker predicts the grant from a
//   plain round-robin model and queues the expected product with its due en-cycle;
//   an independent monitor retires entries against rvalid/result.
//   array_mult itself is modelled as a LAT-deep en-qualified product pipeline.
// -----------------------------------------------------------------------------
module tb_array_mult_arbiter;

   localparam int NREQ  = 2;
   localparam int LANES = 6;
   localparam int W     = 27;
   localparam int LAT   = 4;
   localparam int SLICE = LANES * W;

   logic clk = 1'b0;
   logic rst;
   logic en;

   always #5 clk = ~clk;

   array_mult_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .W(W)) bus ();

   array_mult_arbiter #(.NREQ(NREQ), .LANES(LANES), .W(W), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus.slave)
   );

   typedef struct {
      int               id;
      logic [SLICE-1:0] prod;
      longint           due;
   } exp_t;

   exp_t             sb[$];
   int               issue_log[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   logic [SLICE-1:0] opa [NREQ];
   logic [SLICE-1:0] opb [NREQ];
   logic [NREQ-1:0]  gnt_seen = '0;

   // Lane-wise W-bit product (low W bits), the behaviour of array_mult.
   function automatic logic [SLICE-1:0] lane_mult(input logic [SLICE-1:0] a, input logic [SLICE-1:0] b);
      logic [SLICE-1:0] r;
      logic [2*W-1:0]   p;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         p            = a[l*W +: W] * b[l*W +: W];
         r[l*W +: W]  = p[W-1:0];
      end
      return r;
   endfunction

   function automatic logic [SLICE-1:0] rand_slice();
      logic [SLICE-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*W +: W] = W'($urandom);
      return r;
   endfunction

   // ---------------- array_mult model ----------------
   logic [SLICE-1:0] am_pipe [LAT];
   always @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < LAT; s++) am_pipe[s] <= '0;
      end else if (en) begin
         am_pipe[0] <= lane_mult(bus.mult_dataa, bus.mult_datab);
         for (int s = 1; s < LAT; s++) am_pipe[s] <= am_pipe[s-1];
      end
   end
   assign bus.mult_result = am_pipe[LAT-1];

   task automatic check(input string name, input logic [SLICE-1:0] act, input logic [SLICE-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- tracker: grant prediction and scoreboard push ----------------
   int     m_ptr      = 0;
   bit     m_rst_prev = 1'b0;
   longint t_cnt      = 0;

   always @(negedge clk) begin : tracker
      logic [NREQ-1:0]  e_gnt;
      logic [SLICE-1:0] ea, eb;
      int               g, c;
      exp_t             e;
      e_gnt = '0;
      ea    = '0;
      eb    = '0;
      g     = -1;
      if (en && !rst && !m_rst_prev) begin
         for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req[c]) g = c;
         end
      end
      if (g >= 0) begin
         e_gnt[g] = 1'b1;
         ea       = opa[g];
         eb       = opb[g];
      end
      gnt_seen = bus.gnt;
      check("gnt", SLICE'(bus.gnt), SLICE'(e_gnt));
      check("mult_dataa", bus.mult_dataa, ea);
      check("mult_datab", bus.mult_datab, eb);
      if (rst) begin
         sb.delete();
         m_ptr = 0;
      end else if (g >= 0) begin
         e.id   = g;
         e.prod = lane_mult(ea, eb);
         e.due  = t_cnt + LAT;
         sb.push_back(e);
         issue_log.push_back(g);
         m_ptr = bus.lock[g] ? g : (g + 1) % NREQ;
      end
      if (en) t_cnt++;
      m_rst_prev = rst;
   end

   // ---------------- monitor: retire and compare ----------------
   longint m_cnt = 0;

   always @(negedge clk) begin : monitor
      logic [NREQ-1:0] e_rv;
      e_rv = '0;
      if (!rst && en && sb.size() > 0 && sb[0].due == m_cnt) begin
         e_rv[sb[0].id] = 1'b1;
         check("result", bus.result, sb[0].prod);
         void'(sb.pop_front());
      end
      check("rvalid", SLICE'(bus.rvalid), SLICE'(e_rv));
      if (en) m_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.dataa[i*SLICE +: SLICE] = opa[i];
         bus.datab[i*SLICE +: SLICE] = opb[i];
      end
   endtask

   // Advance one cycle; a requester that was just granted moves on to new operands.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_seen[i]) begin
            opa[i] = rand_slice();
            opb[i] = rand_slice();
         end
      end
      drive();
   endtask

   task automatic check_log(input string name, input int e[$]);
      check({name, "_len"}, SLICE'(issue_log.size()), SLICE'(e.size()));
      for (int k = 0; k < e.size() && k < issue_log.size(); k++)
         check(name, SLICE'(issue_log[k]), SLICE'(e[k]));
      issue_log.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      issue_log.delete();
   endtask

   initial begin : stim
      int exp_q[$];
      rst      = 1'b1;
      en       = 1'b1;
      bus.req  = '1;
      bus.lock = '0;
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = rand_slice();
         opb[i] = rand_slice();
      end
      drive();

      // Reset held two cycles with both requesting; the cycle after stays quiet too.
      step();
      step();
      rst = 1'b0;
      step();
      bus.req = '0;
      issue_log.delete();
      step();

      // Single issue: lane0 3*5.
      opa[0]  = '0;
      opb[0]  = '0;
      opa[0][W-1:0] = W'(3);
      opb[0][W-1:0] = W'(5);
      drive();
      bus.req = 2'b01;
      step();
      bus.req = '0;
      for (int n = 0; n < LAT + 2; n++) step();
      exp_q = {0};
      check_log("seq_single", exp_q);

      // Contention without lock alternates.
      do_reset();
      step();
      bus.req = 2'b11;
      for (int n = 0; n < 4; n++) step();
      bus.req = '0;
      exp_q = {0, 1, 0, 1};
      check_log("seq_contention", exp_q);
      for (int n = 0; n < LAT + 1; n++) step();

      // Lock keeps requester 0 for three issues, then rotation resumes.
      bus.req  = 2'b11;
      bus.lock = 2'b01;
      step();
      step();
      bus.lock = '0;
      for (int n = 0; n < 3; n++) step();
      bus.req = '0;
      exp_q = {0, 0, 0, 1, 0};
      check_log("seq_lock", exp_q);
      for (int n = 0; n < LAT + 1; n++) step();

      // Stall: one issue then three en=0 cycles with requests pending.
      bus.req = 2'b01;
      step();
      en      = 1'b0;
      bus.req = 2'b11;
      for (int n = 0; n < 3; n++) step();
      bus.req = '0;
      en      = 1'b1;
      for (int n = 0; n < LAT + 2; n++) step();
      exp_q = {0};
      check_log("seq_stall", exp_q);

      // Reset with a product in flight; pointer returns to 0.
      bus.req = 2'b10;
      step();
      bus.req = '0;
      step();
      bus.req = 2'b11;
      do_reset();
      step();
      step();
      step();
      bus.req = '0;
      exp_q = {0, 1};
      check_log("seq_after_reset", exp_q);
      for (int n = 0; n < LAT + 2; n++) step();

      // Randomized traffic honouring the hold-until-granted contract.
      for (int n = 0; n < 600; n++) begin
         en  = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 149) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_seen[i]) begin
               bus.req[i] = 1'($urandom_range(0, 1));
            end else if (bus.req[i]) begin
               if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               bus.req[i] = 1'b1;
               opa[i]     = rand_slice();
               opb[i]     = rand_slice();
            end
            bus.lock[i] = ($urandom_range(0, 3) == 0);
         end
         drive();
         step();
      end

      // Drain.
      rst      = 1'b0;
      en       = 1'b1;
      bus.req  = '0;
      bus.lock = '0;
      for (int n = 0; n < LAT + 3; n++) step();
      check("drain", SLICE'(sb.size()), SLICE'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
